// File: rtl/tcam_route_writer.sv
// Route-table programming engine: keeps a shadow of every TCAM entry, scans it for a
// matching or free slot and drives the TCAM write port for add, delete and flush commands.
module tcam_route_writer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [WIDTH-1:0]   cmd_prefix_i,
  input  logic [5:0]         cmd_len_i,
  input  logic [3:0]         cmd_if_idx_i,
  output logic               rsp_valid_o,
  output logic [1:0]         rsp_status_o,
  output logic [IDX_W-1:0]   rsp_index_o,
  output logic               wr_en_o,
  output logic [IDX_W-1:0]   wr_index_o,
  output logic [2*WIDTH+3:0] wr_data_o,
  output logic [IDX_W:0]     entry_count_o
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpFlush = 2'b10;
  localparam logic [1:0] OpRsvd = 2'b11;
  localparam logic [1:0] RspOk = 2'b00;
  localparam logic [1:0] RspFull = 2'b01;
  localparam logic [1:0] RspNotFound = 2'b10;
  localparam logic [1:0] RspBadCmd = 2'b11;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SIZE - 1);
  localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);
  localparam logic [IDX_W:0] CntOne = (IDX_W + 1)'(1);
  localparam logic [2*WIDTH+3:0] InvalidEntry = {4'hF, {(2 * WIDTH){1'b0}}};

  typedef enum logic [2:0] {StIdle, StScan, StWrite, StFlush, StResp} state_e;

  state_e state_q, state_d;

  logic [1:0]       op_q, status_q;
  logic [WIDTH-1:0] mask_q, prefix_q;
  logic [3:0]       if_q;
  logic [IDX_W-1:0] scan_idx_q, match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [IDX_W-1:0] rsp_idx_q, wr_idx_q;
  logic             match_found_q, match_found_d, free_found_q, free_found_d, is_new_q;
  logic [SIZE-1:0]  valid_q;
  logic [WIDTH-1:0] mask_tbl_q [SIZE];
  logic [WIDTH-1:0] pfx_tbl_q  [SIZE];
  logic [IDX_W:0]   count_q;

  logic             bad_cmd, cur_match, last_idx, write_go;
  logic [6:0]       cmd_shift;
  logic [WIDTH-1:0] cmd_mask;
  logic [IDX_W-1:0] target_idx;

  assign bad_cmd   = (cmd_op_i == OpRsvd) || ({1'b0, cmd_len_i} > 7'(WIDTH));
  assign cmd_shift = 7'(WIDTH) - {1'b0, cmd_len_i};
  assign cmd_mask  = (cmd_len_i == 6'd0) ? '0 : ({WIDTH{1'b1}} << cmd_shift);
  assign last_idx  = (scan_idx_q == LastIdx);
  assign cur_match = valid_q[scan_idx_q] && (mask_tbl_q[scan_idx_q] == mask_q) &&
                     (pfx_tbl_q[scan_idx_q] == prefix_q);

  // Running scan result including the entry examined this cycle.
  always_comb begin
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    if (state_q == StScan) begin
      if (!match_found_q && cur_match) begin
        match_found_d = 1'b1;
        match_idx_d   = scan_idx_q;
      end
      if (!free_found_q && !valid_q[scan_idx_q]) begin
        free_found_d = 1'b1;
        free_idx_d   = scan_idx_q;
      end
    end
  end

  assign write_go   = match_found_d || ((op_q == OpAdd) && free_found_d);
  assign target_idx = match_found_d ? match_idx_d : free_idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (bad_cmd)                  state_d = StResp;
          else if (cmd_op_i == OpFlush) state_d = StFlush;
          else                          state_d = StScan;
        end
      end
      StScan:  if (last_idx) state_d = write_go ? StWrite : StResp;
      StWrite: state_d = StResp;
      StFlush: if (last_idx) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reset gates every strobe combinationally so an abort takes effect in the same cycle.
  always_comb begin
    cmd_ready_o  = (state_q == StIdle) && !rst_i;
    wr_en_o      = 1'b0;
    wr_index_o   = '0;
    wr_data_o    = '0;
    rsp_valid_o  = 1'b0;
    rsp_status_o = '0;
    rsp_index_o  = '0;
    if (!rst_i) begin
      unique case (state_q)
        StWrite: begin
          wr_en_o    = 1'b1;
          wr_index_o = wr_idx_q;
          wr_data_o  = (op_q == OpAdd) ? {if_q, mask_q, prefix_q} : InvalidEntry;
        end
        StFlush: begin
          wr_en_o    = 1'b1;
          wr_index_o = scan_idx_q;
          wr_data_o  = InvalidEntry;
        end
        StResp: begin
          rsp_valid_o  = 1'b1;
          rsp_status_o = status_q;
          rsp_index_o  = rsp_idx_q;
        end
        default: ;
      endcase
    end
  end

  assign entry_count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q <= '0; mask_q <= '0; prefix_q <= '0; if_q <= '0;
      scan_idx_q <= '0; status_q <= '0; rsp_idx_q <= '0; wr_idx_q <= '0;
      match_found_q <= 1'b0; match_idx_q <= '0; free_found_q <= 1'b0; free_idx_q <= '0;
      is_new_q <= 1'b0; valid_q <= '0; count_q <= '0;
    end else begin
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            op_q          <= cmd_op_i;
            mask_q        <= cmd_mask;
            prefix_q      <= cmd_prefix_i & cmd_mask;
            if_q          <= cmd_if_idx_i;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            status_q      <= bad_cmd ? RspBadCmd : RspOk;
            rsp_idx_q     <= '0;
          end
        end
        StScan: begin
          scan_idx_q <= scan_idx_q + IdxOne;
          if (last_idx) begin
            wr_idx_q <= target_idx;
            is_new_q <= !match_found_d;
            if (write_go)           rsp_idx_q <= target_idx;
            else if (op_q == OpAdd) status_q  <= RspFull;
            else                    status_q  <= RspNotFound;
          end
        end
        StWrite: begin
          if (op_q == OpAdd) begin
            valid_q[wr_idx_q] <= 1'b1;
            if (is_new_q) count_q <= count_q + CntOne;
          end else begin
            valid_q[wr_idx_q] <= 1'b0;
            count_q           <= count_q - CntOne;
          end
        end
        StFlush: begin
          scan_idx_q <= scan_idx_q + IdxOne;
          if (last_idx) begin
            valid_q <= '0;
            count_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Key storage needs no reset: an entry is only compared while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == StWrite) && (op_q == OpAdd)) begin
      mask_tbl_q[wr_idx_q] <= mask_q;
      pfx_tbl_q[wr_idx_q]  <= prefix_q;
    end
  end

endmodule

// File: doc/tcam_route_writer.md
# tcam_route_writer

Route-table programming engine that fills the lookup TCAM. It accepts add, delete and flush commands over a valid/ready handshake and keeps a shadow copy of every TCAM entry. It scans that copy to find a matching or free slot, then drives the TCAM write port (`wr_en`/`wr_index`/`wr_data`). It is the writer side of the route-lookup TCAM, which only ever reads.

## Interface
- `WIDTH`, 32: address/prefix width in bits.
- `SIZE`, 8: number of TCAM entries.
- `IDX_W`, 3: entry index width, equal to log2(`SIZE`).
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_op`  in  2: 00 add/replace, 01 delete, 10 flush, 11 reserved.
- `cmd_prefix`  in  `WIDTH`: route prefix (host bits may be nonzero).
- `cmd_len`  in  6: prefix length, 0..`WIDTH`.
- `cmd_if_idx`  in  4: egress interface; 4'hF is reserved.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_status`  out  2: 00 OK, 01 FULL, 10 NOT_FOUND, 11 BAD_CMD.
- `rsp_index`  out  `IDX_W`: slot written (0 when no write occurs).
- `wr_en`  out  1: TCAM write strobe, one cycle.
- `wr_index`  out  `IDX_W`: TCAM slot.
- `wr_data`  out  2*`WIDTH`+4: [2W+3:2W] if_idx, [2W-1:W] netmask, [W-1:0] prefix.
- `entry_count`  out  `IDX_W`+1: number of valid entries.

## Operation
- Handshake: a command transfers when `cmd_valid && cmd_ready`. `cmd_ready` is 1 only in IDLE. All command fields are latched at acceptance.
- Netmask: `len`==0 gives all-zeros; otherwise `{WIDTH{1}} << (WIDTH-len)`. The stored prefix is `cmd_prefix & netmask`.
- Shadow table: per entry, a valid bit, netmask and masked prefix. An entry matches when it is valid and both its netmask and masked prefix are equal to the command's. The same prefix with a different length is a distinct entry.
- FSM states: IDLE, SCAN, WRITE, FLUSH, RESP.
  - IDLE to RESP(BAD_CMD) when `cmd_op`=11 or `cmd_len` > `WIDTH`.
  - IDLE to FLUSH on op 10.
  - IDLE to SCAN otherwise.
  - SCAN examines one entry per cycle, indices 0 to `SIZE`-1. It records the first match index and the lowest free index.
- Add:
  - On a match, rewrite that slot (replacing `if_idx`); status OK.
  - Otherwise write the lowest free slot, set its valid bit, increment `entry_count`; status OK.
  - With no match and no free slot, go to RESP(FULL) with no write.
- Delete:
  - On a match, write `{4'hF, {W{0}}, {W{0}}}` to that slot, clear its valid bit, decrement `entry_count`; status OK.
  - With no match, go to RESP(NOT_FOUND) with no write.
  - Slots carrying `if_idx` 4'hF are "no route" in forwarding.
- Flush: write the invalid pattern to slots 0..`SIZE`-1, one per cycle, clear all valid bits, set `entry_count` to 0. Respond OK with `rsp_index` 0.
- Reset does not write the TCAM; software issues a flush after reset.

## Timing
- Reset values: `cmd_ready` 0 while `rst` is high, then 1 on the first cycle after release. All other outputs are 0; the shadow table is all-invalid.
- Command accepted at cycle T0.
- Scan: SCAN occupies T1..T`SIZE`. WRITE (`wr_en`=1) is at T`SIZE`+1 and RESP at T`SIZE`+2. Without a write, RESP is at T`SIZE`+1.
- BAD_CMD: RESP at T1.
- Flush: `wr_en` at T1..T`SIZE`, RESP at T`SIZE`+1.
- `cmd_ready` returns to 1 on the cycle after RESP. Back-to-back commands are therefore spaced by the full latency.
- `entry_count` and the shadow table update at the clock edge that ends the WRITE cycle or the last FLUSH cycle.
- `wr_index`/`wr_data` are valid only while `wr_en`=1; they are 0 otherwise.
- `rsp_status`/`rsp_index` are valid only while `rsp_valid`=1.
- Reset mid-operation aborts immediately: no further `wr_en` or `rsp_valid`. A partially completed flush leaves the shadow table all-invalid.

## Test plan
- Reset, then add 0xC0A80000/24 if 2. Required: `wr_en` at T9 with idx 0 and `wr_data`={4'h2, 32'hFFFFFF00, 32'hC0A80000}; `rsp_valid` at T10 with OK, idx 0; `entry_count`=1.
- Add 0xC0A8004D/24 if 5. Required: replaces idx 0 with `wr_data` prefix 0xC0A80000 and if 5; `entry_count` stays 1. Then add 0xC0A80000/16 if 3. Required: new slot idx 1, `entry_count`=2.
- Fill 8 distinct routes, then add a 9th. Required: RESP FULL at T9, no `wr_en`, `entry_count`=8.
- Delete 0x0A000000/8 when absent. Required: NOT_FOUND at T9, no write. Delete the route in idx 3. Required: `wr_en` idx 3 with data {F,0,0}, `entry_count` decrements; the next add lands in idx 3.
- `cmd_len`=33, or `cmd_op`=11. Required: BAD_CMD at T1, no write. Add with `cmd_len`=0 and prefix 0xDEADBEEF. Required: netmask 0, prefix 0.
- Flush with 8 entries valid. Required: `wr_en` T1..T8 on idx 0..7, OK at T9, `entry_count`=0. Assert `rst` at T4 of an add scan. Required: no `wr_en`/`rsp_valid`; `cmd_ready`=1 on the cycle after release.
